// File: rtl/text_screen_pkg.sv
// Shared constants, types and helpers for the text screen buffer.
package text_screen_pkg;

  localparam int unsigned ROWS       = 15;
  localparam int unsigned COLS       = 40;
  localparam int unsigned ROW_W      = 4;
  localparam int unsigned COL_W      = 6;
  localparam int unsigned CHAR_W     = 8;
  localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;
  localparam int unsigned PEND_DEPTH = 8;

  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned ADDR_W = $clog2(CELLS);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StScroll,
    StClear
  } state_e;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [CHAR_W-1:0] ch;
  } pend_wr_t;

  // Linear cell index; only meaningful when cell_ok() holds.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  function automatic logic cell_ok(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return (32'(row) < ROWS) && (32'(col) < COLS);
  endfunction

endpackage

// File: rtl/text_write_fifo.sv
// Synchronous FIFO holding feeder writes that arrive while the screen is busy.
module text_write_fifo
  import text_screen_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_i,
  input  logic     push_i,
  input  pend_wr_t wdata_i,
  input  logic     pop_i,
  output pend_wr_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  pend_wr_t        mem_q [Depth];
  logic [PtrW:0]   wptr_q, wptr_d;
  logic [PtrW:0]   rptr_q, rptr_d;

  // Extra pointer bit distinguishes full from empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  // Pointer next-state: flush empties the queue and overrides push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i && !full_o) wptr_d = wptr_q + 1'b1;
      if (pop_i && !empty_o) rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !flush_i) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/text_screen_buffer.sv
// Character-cell screen memory with scroll, clear, queued writes and a registered
// scan-out read port. Optional cursor tracking is built when TEXT_SCREEN_CURSOR_EN
// is defined; otherwise cursor_hit is tied low.
module text_screen_buffer
  import text_screen_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              push_up,
  input  logic              reset_call,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [CHAR_W-1:0] rd_char,
  output logic              cursor_hit,
  output logic              busy,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] CellsA  = ADDR_W'(CELLS);
  localparam logic [ADDR_W-1:0] LastA   = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] ColsA   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CopyEnd = ADDR_W'(CELLS - COLS);

  logic [CHAR_W-1:0] mem_q [CELLS];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
  logic [CHAR_W-1:0] pipe_data_q, pipe_data_d;
  logic [CHAR_W-1:0] rd_char_q, rd_char_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CHAR_W-1:0] mem_wdata;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  pend_wr_t          fifo_wdata, fifo_head;

  logic              wr_req, enq;
  logic [ADDR_W-1:0] src_addr;
  logic              rd_ok;
  logic [ADDR_W-1:0] rd_addr;

  assign wr_req     = wr_en && cell_ok(wr_row, wr_col);
  assign fifo_wdata = '{row: wr_row, col: wr_col, ch: wr_char};
  // Source index is muxed to 0 outside the copy range to keep the read in bounds.
  assign src_addr   = (cnt_q < CopyEnd) ? cnt_q + ColsA : '0;
  assign rd_ok      = cell_ok(rd_row, rd_col);
  assign rd_addr    = rd_ok ? cell_addr(rd_row, rd_col) : '0;

  text_write_fifo #(
    .Depth (PEND_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM next-state, memory write-port arbitration and queueing decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    pipe_vld_d  = 1'b0;
    pipe_addr_d = pipe_addr_q;
    pipe_data_d = pipe_data_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    enq         = 1'b0;
    // The scroll pipeline's pending write always commits, even on an abort edge.
    mem_we      = pipe_vld_q;
    mem_waddr   = pipe_addr_q;
    mem_wdata   = pipe_data_q;

    if (reset_call) begin
      state_d    = StClear;
      cnt_d      = '0;
      pend_d     = 1'b0;
      fifo_flush = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDrain: begin
          if (fifo_empty) begin
            if (wr_req) begin
              mem_we    = 1'b1;
              mem_waddr = cell_addr(wr_row, wr_col);
              mem_wdata = wr_char;
            end
            // A write in the same cycle lands first, then the scroll reads it.
            if (push_up || pend_q) begin
              state_d = StScroll;
              cnt_d   = '0;
              pend_d  = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            if (state_q == StDrain) begin
              fifo_pop  = 1'b1;
              mem_we    = 1'b1;
              mem_waddr = cell_addr(fifo_head.row, fifo_head.col);
              mem_wdata = fifo_head.ch;
            end
            enq = 1'b1;
            if (push_up) pend_d = 1'b1;
            state_d = StDrain;
          end
        end
        StScroll: begin
          enq = 1'b1;
          if (cnt_q != CellsA) begin
            if (push_up) pend_d = 1'b1;
            pipe_vld_d  = 1'b1;
            pipe_addr_d = cnt_q;
            pipe_data_d = (cnt_q < CopyEnd) ? mem_q[src_addr] : BLANK_CHAR;
            cnt_d       = cnt_q + 1'b1;
          end else begin
            // Flush cycle: last row write retires; chain a merged request if any.
            cnt_d = '0;
            if (push_up || pend_q) begin
              pend_d = 1'b0;
            end else if (!fifo_empty) begin
              state_d = StDrain;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StClear: begin
          enq       = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = BLANK_CHAR;
          if (push_up) pend_d = 1'b1;
          if (cnt_q == LastA) begin
            cnt_d = '0;
            if (!fifo_empty) begin
              state_d = StDrain;
            end else if (push_up || pend_q) begin
              state_d = StScroll;
              pend_d  = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (enq && wr_req) begin
        if (fifo_full) ovf_d = 1'b1;
        else           fifo_push = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= '0;
      pipe_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  // Screen storage; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Scan-out read mux; out-of-range cells read as blank.
  always_comb begin
    rd_char_d = rd_ok ? mem_q[rd_addr] : BLANK_CHAR;
  end

  // Registered read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_char_q <= '0;
    else          rd_char_q <= rd_char_d;
  end

  assign rd_char  = rd_char_q;
  assign busy     = (state_q == StScroll) || (state_q == StClear);
  assign overflow = ovf_q;

`ifdef TEXT_SCREEN_CURSOR_EN
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic              cursor_hit_q, cursor_hit_d;
  logic              cur_app, cur_scroll;

  // Feeder writes are the only memory writes taken in IDLE/DRAIN.
  assign cur_app    = mem_we && ((state_q == StIdle) || (state_q == StDrain));
  assign cur_scroll = (state_q == StScroll) && (cnt_q == CellsA);

  // Cursor follows the last applied write and moves up one row per scroll.
  always_comb begin
    cursor_d = cursor_q;
    if (reset_call) begin
      cursor_d = '0;
    end else if (cur_app) begin
      cursor_d = (mem_waddr == LastA) ? '0 : mem_waddr + 1'b1;
    end else if (cur_scroll) begin
      cursor_d = (cursor_q >= ColsA) ? cursor_q - ColsA : '0;
    end
    cursor_hit_d = rd_ok && (rd_addr == cursor_q);
  end

  // Cursor and hit registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cursor_q     <= '0;
      cursor_hit_q <= 1'b0;
    end else begin
      cursor_q     <= cursor_d;
      cursor_hit_q <= cursor_hit_d;
    end
  end

  assign cursor_hit = cursor_hit_q;
`else
  assign cursor_hit = 1'b0;
`endif

endmodule

// File: tb/tb_text_screen_buffer.sv
// Directed self-checking bench for text_screen_buffer.
module tb_text_screen_buffer;

  localparam int NR = 15;
  localparam int NC = 40;
  localparam logic [7:0] BL = 8'h20;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [3:0] wr_row;
  logic [5:0] wr_col;
  logic [7:0] wr_char;
  logic       push_up;
  logic       reset_call;
  logic [3:0] rd_row;
  logic [5:0] rd_col;
  logic [7:0] rd_char;
  logic       cursor_hit;
  logic       busy;
  logic       overflow;

  int vec_cnt;
  int err_cnt;
  logic [7:0] model [NR][NC];

  text_screen_buffer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_char    (wr_char),
    .push_up    (push_up),
    .reset_call (reset_call),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_char    (rd_char),
    .cursor_hit (cursor_hit),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input int r, input int c, input logic [7:0] ch);
    wr_en = 1'b1; wr_row = 4'(r); wr_col = 6'(c); wr_char = ch;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_push();
    push_up = 1'b1;
    tick();
    push_up = 1'b0;
  endtask

  task automatic pulse_clear();
    reset_call = 1'b1;
    tick();
    reset_call = 1'b0;
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] ch, output logic hit);
    rd_row = 4'(r); rd_col = 6'(c);
    tick();
    ch  = rd_char;
    hit = cursor_hit;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) model[r][c] = BL;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < NR - 1; r++) for (int c = 0; c < NC; c++) model[r][c] = model[r+1][c];
    for (int c = 0; c < NC; c++) model[NR-1][c] = BL;
  endtask

  task automatic check_screen(input string name);
    int bad, fr, fc;
    logic [7:0] ch, fa, fe;
    logic hit;
    bad = 0; fr = 0; fc = 0; fa = '0; fe = '0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        read_cell(r, c, ch, hit);
        if (ch !== model[r][c]) begin
          if (bad == 0) begin fr = r; fc = c; fa = ch; fe = model[r][c]; end
          bad++;
        end
      end
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL %s: %0d cells differ, first (%0d,%0d) read %h required %h",
               name, bad, fr, fc, fa, fe);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    tick();
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++;
    if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    vec_cnt++;
    if (rd_char !== 8'h00) begin err_cnt++; $display("FAIL reset_rd: got %h want 00", rd_char); end
    vec_cnt++;
    if (cursor_hit !== 1'b0) begin err_cnt++; $display("FAIL reset_hit: got %b want 0", cursor_hit); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    int n;
    logic [7:0] ch;
    logic hit;
    pulse_clear();
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL clear_busy: got %b want 1", busy); end
    wait_idle("clear", n);
    vec_cnt++;
    if (n != 600) begin err_cnt++; $display("FAIL clear_len: got %0d cycles want 600", n); end
    model_clear();
    do_write(2, 5, 8'h41);
    model[2][5] = 8'h41;
    read_cell(2, 5, ch, hit);
    vec_cnt++;
    if (ch !== 8'h41) begin err_cnt++; $display("FAIL write_read: got %h want 41", ch); end
    check_screen("clear_screen");
  endtask

  task automatic test_scroll();
    int n;
    for (int c = 0; c < NC; c++) begin
      do_write(1, c, 8'h42);
      model[1][c] = 8'h42;
    end
    pulse_push();
    wait_idle("scroll", n);
    vec_cnt++;
    if (n < 599 || n > 601) begin
      err_cnt++; $display("FAIL scroll_len: got %0d cycles want 600+-1", n);
    end
    model_scroll();
    repeat (3) tick();
    check_screen("scroll_screen");
  endtask

  task automatic test_queue();
    int n;
    int cols [5] = '{0, 1, 2, 1, 3};
    pulse_push();
    model_scroll();
    for (int i = 0; i < 5; i++) begin
      do_write(3, cols[i], 8'h61 + 8'(i));
      model[3][cols[i]] = 8'h61 + 8'(i);
    end
    wait_idle("queue", n);
    repeat (12) tick();
    vec_cnt++;
    if (overflow !== 1'b0) begin err_cnt++; $display("FAIL queue_ovf: got %b want 0", overflow); end
    check_screen("queue_screen");
  endtask

  task automatic test_bounds();
    logic [7:0] ch;
    logic hit;
    do_write(15, 0, 8'h51);
    do_write(0, 40, 8'h51);
    do_write(0, 63, 8'h51);
    repeat (2) tick();
    check_screen("bounds_screen");
    read_cell(15, 3, ch, hit);
    vec_cnt++;
    if (ch !== BL) begin err_cnt++; $display("FAIL oob_row_read: got %h want 20", ch); end
    read_cell(0, 45, ch, hit);
    vec_cnt++;
    if (ch !== BL) begin err_cnt++; $display("FAIL oob_col_read: got %h want 20", ch); end
  endtask

  task automatic test_overflow();
    int n;
    pulse_push();
    model_scroll();
    for (int i = 0; i < 9; i++) begin
      do_write(4, i, 8'h30 + 8'(i));
      if (i < 8) model[4][i] = 8'h30 + 8'(i);
    end
    wait_idle("ovf", n);
    repeat (12) tick();
    vec_cnt++;
    if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    check_screen("ovf_screen");
  endtask

  task automatic test_same_cycle();
    int n;
    logic [7:0] ch;
    logic hit;
    wr_en = 1'b1; wr_row = 4'd0; wr_col = 6'd39; wr_char = 8'h5a; push_up = 1'b1;
    tick();
    wr_en = 1'b0; push_up = 1'b0;
    model[0][39] = 8'h5a;
    model_scroll();
    wait_idle("same", n);
    repeat (3) tick();
    read_cell(0, 39, ch, hit);
    vec_cnt++;
    if (ch !== model[0][39]) begin
      err_cnt++; $display("FAIL same_cycle_cell: got %h want %h", ch, model[0][39]);
    end
    check_screen("same_cycle_screen");
  endtask

  task automatic test_abort();
    int n;
    pulse_push();
    repeat (100) tick();
    do_write(5, 0, 8'h71);
    do_write(5, 1, 8'h72);
    do_write(6, 2, 8'h73);
    pulse_clear();
    wait_idle("abort", n);
    vec_cnt++;
    if (n != 600) begin err_cnt++; $display("FAIL abort_clear_len: got %0d want 600", n); end
    repeat (12) tick();
    model_clear();
    check_screen("abort_screen");
  endtask

  task automatic test_cursor();
    logic [7:0] ch;
    logic hit;
`ifdef TEXT_SCREEN_CURSOR_EN
    read_cell(0, 0, ch, hit);
    vec_cnt++;
    if (hit !== 1'b1) begin err_cnt++; $display("FAIL cur_init: got %b want 1", hit); end
    do_write(0, 0, 8'h63);
    do_write(0, 1, 8'h64);
    read_cell(0, 2, ch, hit);
    vec_cnt++;
    if (hit !== 1'b1) begin err_cnt++; $display("FAIL cur_02: got %b want 1", hit); end
    read_cell(0, 1, ch, hit);
    vec_cnt++;
    if (hit !== 1'b0) begin err_cnt++; $display("FAIL cur_01: got %b want 0", hit); end
    vec_cnt++;
    if (ch !== 8'h64) begin err_cnt++; $display("FAIL cur_data: got %h want 64", ch); end
    pulse_clear();
    begin int n; wait_idle("cur_clear", n); end
    read_cell(0, 0, ch, hit);
    vec_cnt++;
    if (hit !== 1'b1) begin err_cnt++; $display("FAIL cur_after_clear: got %b want 1", hit); end
    read_cell(0, 2, ch, hit);
    vec_cnt++;
    if (hit !== 1'b0) begin err_cnt++; $display("FAIL cur_02_cleared: got %b want 0", hit); end
`else
    do_write(0, 0, 8'h63);
    read_cell(0, 1, ch, hit);
    vec_cnt++;
    if (hit !== 1'b0) begin err_cnt++; $display("FAIL cur_off_01: got %b want 0", hit); end
    read_cell(0, 0, ch, hit);
    vec_cnt++;
    if (hit !== 1'b0) begin err_cnt++; $display("FAIL cur_off_00: got %b want 0", hit); end
    vec_cnt++;
    if (ch !== 8'h63) begin err_cnt++; $display("FAIL cur_off_data: got %h want 63", ch); end
`endif
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_char = '0;
    push_up = 1'b0; reset_call = 1'b0; rd_row = '0; rd_col = '0;
    test_reset();
    test_clear();
    test_scroll();
    test_queue();
    test_bounds();
    test_overflow();
    test_same_cycle();
    test_abort();
    test_cursor();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/text_screen_buffer.md
Name: text_screen_buffer

Overview:
Character-cell screen memory sitting directly downstream of the character feeder. It stores one 8-bit character id per (row, col) cell and applies the feeder's cell writes. It executes the feeder's push_up as a one-row scroll and its reset_call as a full clear. A registered read port serves the display scan-out stage. Writes arriving while a scroll or clear runs are queued in a small FIFO so no feeder write is lost.

Parameters:
ROWS, 15, number of text rows
COLS, 40, characters per row
ROW_W, 4, row index width (ceil(log2(ROWS)))
COL_W, 6, column index width (ceil(log2(COLS)))
CHAR_W, 8, character id width
BLANK_CHAR, 8'h20, fill value used by scroll and clear
PEND_DEPTH, 8, pending-write FIFO depth (power of 2)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  cell write strobe, aligned with wr_row/wr_col/wr_char
wr_row  in  ROW_W  target row (feeder row_out)
wr_col  in  COL_W  target column (feeder col_out)
wr_char  in  CHAR_W  character id to store
push_up  in  1  one-cycle scroll request
reset_call  in  1  one-cycle clear request
rd_row  in  ROW_W  scan-out read row
rd_col  in  COL_W  scan-out read column
rd_char  out  CHAR_W  cell contents, 1-cycle latency
cursor_hit  out  1  read cell is the cursor cell (optional feature)
busy  out  1  scroll or clear in progress
overflow  out  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (async, reset_n=0): FSM→IDLE; FIFO empty; scroll_pending=0; busy=0; overflow=0; rd_char=0; cursor_hit=0. Memory contents are not reset. Software issues reset_call to blank the screen.
- Address = row*COLS + col, range 0..ROWS*COLS-1. A write with row>=ROWS or col>=COLS is silently dropped.
- States: IDLE, DRAIN, SCROLL, CLEAR.
- IDLE: wr_en writes memory the same edge. Exception: if the FIFO is non-empty, the write enqueues, to keep order.
- DRAIN: one FIFO entry per cycle is written to memory. New wr_en enqueues. Return to IDLE when the FIFO is empty.
- SCROLL: pipelined copy of cell a+COLS into cell a, for a = 0..(ROWS-1)*COLS-1, one cell per cycle. Then the last row is filled with BLANK_CHAR. Total ROWS*COLS cycles (+1 pipeline flush). busy=1. wr_en enqueues.
- CLEAR: write BLANK_CHAR to every cell, ROWS*COLS cycles. busy=1. Return to IDLE.
- Entry to SCROLL/CLEAR happens from IDLE or DRAIN, at the first cycle the FIFO is empty, so queued writes land before the scroll.
- wr_en and push_up in the same cycle: the write is applied or enqueued first, then the scroll starts. This matches the feeder asserting push_up with its final write.
- push_up while SCROLL is active: scroll_pending=1, and one further scroll runs immediately afterwards. Further push_up requests while pending are merged into it.
- reset_call: highest priority in any state. Aborts SCROLL/DRAIN, flushes the FIFO, clears scroll_pending, enters CLEAR next cycle. reset_call during CLEAR restarts the clear from cell 0.
- reset_call with push_up or wr_en in the same cycle: the clear wins; push_up and the write are discarded.
- FIFO full and wr_en while not IDLE-direct: the write is dropped and overflow is set; it stays set until reset_n.
- Read port: rd_char is registered from memory[rd_row*COLS+rd_col] every cycle in every state. An out-of-range read returns BLANK_CHAR. Tearing during a scroll is acceptable.
- busy deasserts the cycle after the last SCROLL/CLEAR write.

Optional Feature:
TEXT_SCREEN_CURSOR_EN defined:
- A cursor register tracks the cell after the last applied write, wrapping at ROWS*COLS to 0.
- Reset value is 0. CLEAR sets it to 0. SCROLL subtracts COLS, saturating at 0.
- cursor_hit is registered alongside rd_char, asserted when the read address equals the cursor.
Macro undefined: cursor_hit is tied to 0 and no cursor logic is built.

Decomposition:
- Package text_screen_pkg: ROWS, COLS, ROW_W, COL_W, CHAR_W, BLANK_CHAR, derived CELLS=ROWS*COLS and ADDR_W, FSM state enum, pending-write struct {row, col, char}.
- Sub-module text_write_fifo: synchronous FIFO of pending-write structs with full/empty flags and a flush input.

Test Plan:
- Reset, reset_call, wait for busy=0, then write (2,5,'A') → read (2,5) returns 8'h41 one cycle later; all other reads return 8'h20; CLEAR took 600 cycles.
- Fill row 1 with 'B', push_up → busy high for 600±1 cycles; afterwards row 0 = 'B', row 14 = 8'h20.
- During a scroll, issue 5 writes to row 3 → all 5 are visible after busy falls, in order; overflow=0. With 9 writes (PEND_DEPTH=8) → 9th is dropped and overflow=1.
- wr_en (0,39,'Z') and push_up on the same cycle → after the scroll, 'Z' is absent from row 0 and row 14 is blank (the write was applied before the scroll, then scrolled off row 0).
- reset_call mid-scroll plus 3 queued writes → FIFO flushed, screen fully BLANK_CHAR, no queued write appears.
- With TEXT_SCREEN_CURSOR_EN: write (0,0) then (0,1) → cursor_hit=1 only when reading (0,2); after reset_call → cursor_hit=1 only when reading (0,0).
